clk_gen_bank: RTL and testbench

CLK_GEN_BANK -- requirements
Module: clk_gen_bank

---
 rtl/clk_gen_bank.sv | 168 ++++++++++++++++
 tb/tb_clk_gen_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_bank.sv
// Bank of programmable divided clocks off a single clkin, with a single pending
// configuration slot that is applied only at the target channel's period boundary.
module clk_gen_bank #(
  parameter int NCH         = 4,
  parameter int DIVW        = 16,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                                     clkin,
  input  logic                                     rstn,
  input  logic                                     cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [DIVW-1:0]                          cfg_div,
  input  logic [DIVW-1:0]                          cfg_high,
  input  logic                                     cfg_en,
  output logic                                     cfg_busy,
  output logic                                     cfg_ack,
  output logic                                     cfg_err,
  output logic [NCH-1:0]                           clkout,
  output logic [NCH-1:0]                           stb,
  output logic                                     lock
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic [LCW-1:0]  lock_cnt_r;
  logic            lock_r;

  logic            pend_v_r;
  logic [CHW-1:0]  pend_ch_r;
  logic [DIVW-1:0] pend_div_r;
  logic [DIVW-1:0] pend_high_r;
  logic            pend_en_r;

  logic [DIVW-1:0] div_r  [NCH];
  logic [DIVW-1:0] high_r [NCH];
  logic [DIVW-1:0] cnt_r  [NCH];
  logic [NCH-1:0]  en_r;
  logic [NCH-1:0]  clkout_r;
  logic [NCH-1:0]  stb_r;
  logic            ack_r;
  logic            err_r;

  logic [DIVW-1:0] div_n_s  [NCH];
  logic [DIVW-1:0] high_n_s [NCH];
  logic [DIVW-1:0] cnt_n_s  [NCH];
  logic [NCH-1:0]  en_n_s;
  logic            apply_s;
  logic            ch_ok_s;
  logic            fields_ok_s;
  logic            valid_s;
  logic            accept_s;

  // Lock counter: counts clkin edges after reset release, then holds lock high.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      lock_cnt_r <= {LCW{1'b0}};
      lock_r     <= 1'b0;
    end else if (!lock_r) begin
      lock_cnt_r <= lock_cnt_r + LCW'(1);
      if (lock_cnt_r == LCW'(LOCK_CYCLES - 1)) begin
        lock_r <= 1'b1;
      end
    end
  end

  // Write qualification; period/high fields only matter when enabling.
  always_comb begin
    ch_ok_s     = ({1'b0, cfg_ch} < (CHW + 1)'(NCH));
    fields_ok_s = (cfg_div >= DIVW'(2)) && (cfg_high >= DIVW'(1)) &&
                  (cfg_high <= (cfg_div - DIVW'(1)));
    if (cfg_en) begin
      valid_s = ch_ok_s && fields_ok_s;
    end else begin
      valid_s = ch_ok_s;
    end
    accept_s = cfg_we && lock_r && !pend_v_r && valid_s;
  end

  // Per-channel next state; the pending slot lands only on a period boundary.
  always_comb begin
    apply_s = 1'b0;
    en_n_s  = en_r;
    for (int i = 0; i < NCH; i++) begin
      div_n_s[i]  = div_r[i];
      high_n_s[i] = high_r[i];
      if (!en_r[i]) begin
        cnt_n_s[i] = {DIVW{1'b0}};
      end else if (cnt_r[i] == (div_r[i] - DIVW'(1))) begin
        cnt_n_s[i] = {DIVW{1'b0}};
      end else begin
        cnt_n_s[i] = cnt_r[i] + DIVW'(1);
      end
      if (pend_v_r && (pend_ch_r == CHW'(i)) &&
          (!en_r[i] || (cnt_r[i] == (div_r[i] - DIVW'(1))))) begin
        apply_s    = 1'b1;
        en_n_s[i]  = pend_en_r;
        cnt_n_s[i] = {DIVW{1'b0}};
        // A disable keeps the last legal div/high so the channel state stays valid.
        if (pend_en_r) begin
          div_n_s[i]  = pend_div_r;
          high_n_s[i] = pend_high_r;
        end else begin
          div_n_s[i]  = div_r[i];
          high_n_s[i] = high_r[i];
        end
      end else begin
        en_n_s[i] = en_r[i];
      end
    end
  end

  // Channel registers; clkout/stb are decoded from next state so they are pure flops.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        div_r[i]  <= DIVW'(2);
        high_r[i] <= DIVW'(1);
        cnt_r[i]  <= {DIVW{1'b0}};
      end
      en_r     <= {NCH{1'b0}};
      clkout_r <= {NCH{1'b0}};
      stb_r    <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        div_r[i]    <= div_n_s[i];
        high_r[i]   <= high_n_s[i];
        cnt_r[i]    <= cnt_n_s[i];
        clkout_r[i] <= en_n_s[i] && (cnt_n_s[i] < high_n_s[i]);
        stb_r[i]    <= en_n_s[i] && (cnt_n_s[i] == {DIVW{1'b0}});
      end
      en_r <= en_n_s;
    end
  end

  // Pending slot and handshake pulses.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      pend_v_r    <= 1'b0;
      pend_ch_r   <= {CHW{1'b0}};
      pend_div_r  <= DIVW'(2);
      pend_high_r <= DIVW'(1);
      pend_en_r   <= 1'b0;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      ack_r <= apply_s;
      err_r <= cfg_we && !accept_s;
      if (accept_s) begin
        pend_v_r    <= 1'b1;
        pend_ch_r   <= cfg_ch;
        pend_div_r  <= cfg_div;
        pend_high_r <= cfg_high;
        pend_en_r   <= cfg_en;
      end else if (apply_s) begin
        pend_v_r <= 1'b0;
      end
    end
  end

  assign cfg_busy = pend_v_r;
  assign cfg_ack  = ack_r;
  assign cfg_err  = err_r;
  assign clkout   = clkout_r;
  assign stb      = stb_r;
  assign lock     = lock_r;

endmodule

// File: tb/tb_clk_gen_bank.sv
// Directed bench for clk_gen_bank: stimulus pushes timed expectations into a
// queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_clk_gen_bank;

  logic       clkin = 1'b0;
  logic       rstn;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_en;
  logic       cfg_busy;
  logic       cfg_ack;
  logic       cfg_err;
  logic [2:0] clkout;
  logic [2:0] stb;
  logic       lock;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t  exp_q[$];
  int    cyc      = 0;
  int    n_assert = 0;
  int    n_fail   = 0;
  string names[6] = '{"cfg_err", "cfg_ack", "lock", "cfg_busy", "clkout", "stb"};

  localparam int S_ERR = 0, S_ACK = 1, S_LOCK = 2, S_BUSY = 3, S_CLK = 4, S_STB = 5;

  clk_gen_bank #(.NCH(3), .DIVW(8), .LOCK_CYCLES(16)) dut (
    .clkin(clkin), .rstn(rstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_en(cfg_en),
    .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .clkout(clkout), .stb(stb), .lock(lock)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input int s, input int v);
    exp_t e;
    int   idx;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    idx = exp_q.size();
    while (idx > 0 && exp_q[idx-1].cyc > c) idx--;
    exp_q.insert(idx, e);
  endfunction

  // Monitor: compare all expectations due this cycle, and flag unexpected pulses.
  always @(negedge clkin) begin
    exp_t e;
    bit   seen_err;
    bit   seen_ack;
    int   act;
    seen_err = 1'b0;
    seen_ack = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.sig)
        S_ERR:   act = int'(cfg_err);
        S_ACK:   act = int'(cfg_ack);
        S_LOCK:  act = int'(lock);
        S_BUSY:  act = int'(cfg_busy);
        S_CLK:   act = int'(clkout);
        S_STB:   act = int'(stb);
        default: act = -1;
      endcase
      if (e.sig == S_ERR && e.val == 1) seen_err = 1'b1;
      if (e.sig == S_ACK && e.val == 1) seen_ack = 1'b1;
      n_assert++;
      if (e.cyc != cyc || act != e.val) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %0d, expected %0d (sampled at cycle %0d)",
                 names[e.sig], e.cyc, act, e.val, cyc);
      end
    end
    n_assert++;
    if ((cfg_err && !seen_err) || (cfg_ack && !seen_ack)) begin
      n_fail++;
      $display("FAIL stray_pulse cycle %0d: err=%0b ack=%0b, expected no pulse",
               cyc, cfg_err, cfg_ack);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clkin);
    #1;
  endtask

  task automatic wr(input int c, input logic [1:0] ch, input logic [7:0] dv,
                    input logic [7:0] hi, input logic en);
    wait_cyc(c);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_high = hi;
    cfg_en   = en;
    wait_cyc(c + 1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    int r2;
    int v4[10];
    int v5[9];
    rstn = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_high = 8'd0; cfg_en = 1'b0;
    r  = 4;
    k  = r + 20;
    r2 = k + 50;

    // Reset state and lock timing.
    for (int c = 1; c <= 2; c++) begin
      expect_at(c, S_ERR, 0);  expect_at(c, S_ACK, 0); expect_at(c, S_LOCK, 0);
      expect_at(c, S_BUSY, 0); expect_at(c, S_CLK, 0); expect_at(c, S_STB, 0);
    end
    expect_at(r + 15, S_LOCK, 0);
    expect_at(r + 16, S_LOCK, 1);
    expect_at(r + 4, S_ERR, 1);
    expect_at(r + 4, S_CLK, 0);
    expect_at(r + 10, S_CLK, 0);
    wait_cyc(r);
    rstn = 1'b1;
    wr(r + 3, 2'd0, 8'd4, 8'd2, 1'b1);

    // ch0 div=4 high=2 from a disabled state.
    expect_at(k + 1, S_BUSY, 1);
    expect_at(k + 2, S_ACK, 1);
    for (int j = 0; j < 8; j++) begin
      expect_at(k + 2 + j, S_CLK, ((j % 4) < 2) ? 1 : 0);
      expect_at(k + 2 + j, S_STB, ((j % 4) == 0) ? 1 : 0);
    end
    wr(k, 2'd0, 8'd4, 8'd2, 1'b1);

    // Mid-period change to div=3 high=1: current period completes first.
    v4 = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    for (int j = 0; j < 10; j++) expect_at(k + 10 + j, S_CLK, v4[j]);
    expect_at(k + 12, S_BUSY, 1);
    expect_at(k + 13, S_BUSY, 1);
    expect_at(k + 13, S_ACK, 0);
    expect_at(k + 14, S_ACK, 1);
    expect_at(k + 14, S_BUSY, 0);
    wr(k + 11, 2'd0, 8'd3, 8'd1, 1'b1);

    // Refused write while busy, then a write accepted in the ack cycle.
    v5 = '{1, 0, 0, 1, 1, 5, 0, 4, 1};
    for (int j = 0; j < 9; j++) expect_at(k + 20 + j, S_CLK, v5[j]);
    expect_at(k + 22, S_BUSY, 1);
    expect_at(k + 23, S_BUSY, 0);
    expect_at(k + 24, S_BUSY, 1);
    expect_at(k + 25, S_BUSY, 0);
    expect_at(k + 23, S_ACK, 1);
    expect_at(k + 23, S_ERR, 1);
    expect_at(k + 25, S_ACK, 1);
    expect_at(k + 23, S_STB, 1);
    expect_at(k + 25, S_STB, 4);
    wr(k + 21, 2'd0, 8'd5, 8'd3, 1'b1);
    wr(k + 22, 2'd1, 8'd2, 8'd1, 1'b1);
    wr(k + 23, 2'd2, 8'd2, 8'd1, 1'b1);

    // Illegal field/channel writes, then a disable with don't-care fields.
    for (int j = 1; j <= 4; j++) begin
      expect_at(k + 30 + j, S_ERR, 1);
      expect_at(k + 30 + j, S_BUSY, 0);
    end
    expect_at(k + 35, S_CLK, 5);
    expect_at(k + 37, S_BUSY, 1);
    expect_at(k + 38, S_ACK, 1);
    expect_at(k + 38, S_ERR, 0);
    wr(k + 30, 2'd1, 8'd1, 8'd1, 1'b1);
    wr(k + 31, 2'd1, 8'd4, 8'd0, 1'b1);
    wr(k + 32, 2'd1, 8'd4, 8'd4, 1'b1);
    wr(k + 33, 2'd3, 8'd4, 8'd2, 1'b1);
    wr(k + 36, 2'd1, 8'd0, 8'd0, 1'b0);

    // Reset mid-update with ch0 and ch2 running.
    expect_at(k + 44, S_BUSY, 1);
    expect_at(k + 44, S_CLK, 1);
    expect_at(k + 45, S_CLK, 0);
    expect_at(k + 45, S_STB, 0);
    expect_at(k + 45, S_BUSY, 0);
    expect_at(k + 45, S_LOCK, 0);
    expect_at(r2 + 15, S_LOCK, 0);
    expect_at(r2 + 16, S_LOCK, 1);
    expect_at(r2 + 17, S_CLK, 0);
    expect_at(r2 + 17, S_BUSY, 0);
    wr(k + 43, 2'd0, 8'd8, 8'd4, 1'b1);
    wait_cyc(k + 44);
    @(posedge clkin);
    #2;
    rstn = 1'b0;
    wait_cyc(r2);
    rstn = 1'b1;
    wait_cyc(r2 + 20);

    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
